// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the sequencer state encoding, default bus widths and the idle strobe pattern.
// Imported by dmem_arbiter and dmem_arb_perf.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    HST_RD = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 32;

  // {CEN, WEN, OEN} with every active-low strobe deasserted.
  localparam logic [2:0] STROBE_IDLE = 3'b111;

endpackage

// File: rtl/dmem_arb_perf.sv
// Saturating event counters for the data-memory arbiter (CPU stall cycles, host grants).
// Counts update one cycle after the event; both clear on synchronous reset.
// No backpressure: every event cycle is counted until the counter saturates.
module dmem_arb_perf
  import dmem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_evt,
  input  logic        grant_evt,
  output logic [15:0] perf_cpu_stall,
  output logic [15:0] perf_hst_grants
);

  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] grant_cnt_q, grant_cnt_d;

  // Next counter values: saturate at all-ones, clear while in reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    grant_cnt_d = grant_cnt_q;
    if (stall_evt && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (grant_evt && (grant_cnt_q != 16'hFFFF)) grant_cnt_d = grant_cnt_q + 16'd1;
    if (!rst_n) begin
      stall_cnt_d = '0;
      grant_cnt_d = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    grant_cnt_q <= grant_cnt_d;
  end

  assign perf_cpu_stall  = stall_cnt_q;
  assign perf_hst_grants = grant_cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing one single-port sync SRAM between CPU load/store and a host port.
// Stores take 1 cycle, loads 2 cycles (1 stall); host read data returns the cycle after handshake.
// CPU has fixed priority and is stalled when blocked; host waits on hst_ready, bounded by STARVE_LIMIT.
// Optional DMEM_ARB_PERF_EN adds perf_cpu_stall / perf_hst_grants saturating counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              hst_valid,
  output logic              hst_ready,
  input  logic              hst_we,
  input  logic [ADDR_W-1:0] hst_addr,
  input  logic [DATA_W-1:0] hst_wdata,
  output logic              hst_rvalid,
  output logic [DATA_W-1:0] hst_rdata,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data2Mem,
  input  logic [DATA_W-1:0] ReadDataMem
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_cpu_stall,
  output logic [15:0]       perf_hst_grants
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       hst_rvalid_q, hst_rvalid_d;
  logic       hst_gnt, cpu_gnt;

  // Grant decision, only meaningful when the SRAM is free (IDLE).
  always_comb begin
    hst_gnt = (state_q == IDLE) && hst_valid && (!cpu_req || (starve_cnt_q == LIMIT));
    cpu_gnt = (state_q == IDLE) && !hst_gnt && cpu_req;
  end

  // Next state, starvation counter and all combinational outputs; reset forces everything inactive.
  always_comb begin
    state_d          = state_q;
    starve_cnt_d     = starve_cnt_q;
    hst_rvalid_d     = 1'b0;
    {CEN, WEN, OEN}  = STROBE_IDLE;
    A                = '0;
    Data2Mem         = '0;
    cpu_stall        = 1'b0;
    hst_ready        = 1'b0;
    cpu_rdata        = '0;
    hst_rdata        = '0;
    hst_rvalid       = hst_rvalid_q;

    case (state_q)
      IDLE: begin
        if (hst_gnt) begin
          CEN       = 1'b0;
          WEN       = !hst_we;
          OEN       = hst_we;
          A         = hst_addr;
          Data2Mem  = hst_wdata;
          hst_ready = 1'b1;
          cpu_stall = cpu_req;
          if (!hst_we) begin
            state_d      = HST_RD;
            hst_rvalid_d = 1'b1;
          end
        end else if (cpu_gnt) begin
          CEN       = 1'b0;
          WEN       = !cpu_we;
          OEN       = cpu_we;
          A         = cpu_addr;
          Data2Mem  = cpu_wdata;
          cpu_stall = !cpu_we;
          if (!cpu_we) state_d = CPU_RD;
        end
      end
      CPU_RD: begin
        // Data for the held load arrives now; release the CPU without reissuing.
        cpu_rdata = ReadDataMem;
        state_d   = IDLE;
      end
      HST_RD: begin
        hst_rdata = ReadDataMem;
        cpu_stall = cpu_req;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The counter only measures back-to-back lost arbitrations of a live host request.
    if (!hst_valid || hst_gnt) begin
      starve_cnt_d = '0;
    end else if (cpu_gnt && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    if (!rst_n) begin
      state_d         = IDLE;
      starve_cnt_d    = '0;
      hst_rvalid_d    = 1'b0;
      {CEN, WEN, OEN} = STROBE_IDLE;
      A               = '0;
      Data2Mem        = '0;
      cpu_stall       = 1'b0;
      hst_ready       = 1'b0;
      cpu_rdata       = '0;
      hst_rdata       = '0;
      hst_rvalid      = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    starve_cnt_q <= starve_cnt_d;
    hst_rvalid_q <= hst_rvalid_d;
  end

`ifdef DMEM_ARB_PERF_EN
  dmem_arb_perf u_perf (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_evt       (cpu_req && cpu_stall),
    .grant_evt       (hst_valid && hst_ready),
    .perf_cpu_stall  (perf_cpu_stall),
    .perf_hst_grants (perf_hst_grants)
  );
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the shared single-port 128×32 synchronous data SRAM. It shares the SRAM between the processor load/store port and a host/debug port that is used for program loading and memory inspection. It drives the SRAM's active-low CEN/WEN/OEN strobes and stalls the processor while its access is pending or blocked. CPU has fixed priority; a starvation counter bounds host wait time.

## Interface
- ADDR_W, 7: word address width (128 words).
- DATA_W, 32: data width.
- STARVE_LIMIT, 4: consecutive lost arbitrations before host is forced a grant; legal range 1..15.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_req  in  1  CPU access request (held until cpu_stall low).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data; valid in cycle cpu_req high and cpu_stall low with cpu_we=0.
- cpu_stall  out  1  CPU must hold PC and request.
- hst_valid / hst_ready  in / out  1  host request handshake; transfer on both high.
- hst_we, hst_addr, hst_wdata  in  1 / ADDR_W / DATA_W  host request payload.
- hst_rvalid  out  1  one-cycle pulse, host read data valid.
- hst_rdata  out  DATA_W  host read data.
- CEN, WEN, OEN  out  1  SRAM chip enable / write enable / output enable, all active-low.
- A  out  ADDR_W  SRAM address.
- Data2Mem  out  DATA_W  SRAM write data.
- ReadDataMem  in  DATA_W  SRAM read data, valid the cycle after a read strobe.

## Operation
- States: IDLE, CPU_RD (awaiting CPU load data), HST_RD (awaiting host load data).
- IDLE grant rule:
  - If hst_valid && (!cpu_req || starve_cnt == STARVE_LIMIT), grant host.
  - Else if cpu_req, grant CPU.
  - Else no access.
- Granted access: CEN=0; WEN=!we; OEN=we (OEN low only for reads). A and Data2Mem are taken from the granted port.
- CPU write granted: cpu_stall=0, completes in one cycle, stay IDLE.
- CPU read granted: cpu_stall=1, go to CPU_RD.
- Host granted: hst_ready=1. Write: stay IDLE. Read: go to HST_RD.
- CPU loses to host: cpu_stall=1.
- CPU_RD: CEN/WEN/OEN=1, cpu_rdata=ReadDataMem, cpu_stall=0, hst_ready=0; go to IDLE. The held cpu_req is the same load; it is not reissued.
- HST_RD: hst_rvalid=1, hst_rdata=ReadDataMem, SRAM idle, hst_ready=0, cpu_stall=cpu_req; go to IDLE.
- starve_cnt (4 bits):
  - Increments in IDLE when hst_valid && cpu_req and CPU is granted.
  - Clears on a host grant or when hst_valid is low.
  - Saturates at STARVE_LIMIT.
- When no access is issued: A and Data2Mem hold 0, strobes are high.

## Timing
- CPU store: 0 stall cycles when granted.
- CPU load: exactly 1 stall cycle (2 cycles request-to-data).
- Host read: hst_rvalid rises the cycle after the hst_valid && hst_ready handshake. There is no backpressure on hst_rvalid.
- Host worst-case wait under continuous CPU stores: STARVE_LIMIT cycles, then granted.
- cpu_stall, hst_ready and the SRAM strobes are combinational from state and requests. hst_rvalid, cpu_rdata and hst_rdata are valid only in the wait states.
- During rst_n low:
  - State, starve_cnt and hst_rvalid go to IDLE/0/0 at the clock edge.
  - Outputs are forced inactive: CEN=WEN=OEN=1, A=0, Data2Mem=0, cpu_stall=0, hst_ready=0, rdata=0.
- Reset in CPU_RD or HST_RD: the pending read is abandoned and no rvalid or data is returned.
- hst_valid dropped before handshake: no access occurs and the counter clears.

## Configuration
- DMEM_ARB_PERF_EN defined: adds outputs perf_cpu_stall[15:0] and perf_hst_grants[15:0].
  - Both are saturating counters, cleared by reset.
  - perf_cpu_stall counts cycles with cpu_req && cpu_stall.
  - perf_hst_grants counts host handshakes.
- DMEM_ARB_PERF_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, CPU_RD, HST_RD);
  - ADDR_W/DATA_W defaults;
  - the strobe-inactive constant (3'b111).
- Sub-module dmem_arb_perf contains the two saturating counters. It is instantiated only under DMEM_ARB_PERF_EN.

## Test plan
- CPU store addr 5 = 0xDEADBEEF, then load addr 5:
  - store completes with cpu_stall=0;
  - load sees cpu_stall=1 for one cycle, then cpu_rdata=0xDEADBEEF.
- Host write addr 0x7F = 0x12345678 while CPU is idle: hst_ready=1 the same cycle. Host read addr 0x7F: hst_rvalid pulses the next cycle with 0x12345678.
- cpu_req held with continuous stores and hst_valid high, STARVE_LIMIT=4:
  - CPU granted 4 cycles;
  - cycle 5 grants host with cpu_stall=1;
  - counter returns to 0.
- Host read grant followed by CPU load in HST_RD: cpu_stall=1 for 2 cycles total, then the load completes with correct data.
- Assert rst_n low in CPU_RD: no cpu_rdata is committed, and all strobes=1, cpu_stall=0, hst_ready=0 after the edge.
- With DMEM_ARB_PERF_EN: run the previous 4-grant starvation sequence; perf_hst_grants=1 and perf_cpu_stall=1.
